// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types, Q4.4 scale constants and framebuffer address helper for the sprite blitter
package sprite_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int Q_INT_W = 4;
    localparam int Q_FRAC_W = 4;
    localparam int SCALE_W = Q_INT_W + Q_FRAC_W;
    localparam logic [SCALE_W-1:0] SCALE_ONE = 8'h10;
    function automatic int unsigned fb_lin(int unsigned x, int unsigned y, int unsigned w);
        return y * w + x;
    endfunction
endpackage

// File: rtl/sprite_blit_if.sv
// sprite_blit_if: framebuffer write port between the blitter and the framebuffer arbiter
interface sprite_blit_if #(
    parameter int FB_ADDRW = 19,
    parameter int SPR_DATAW = 4
);
    logic [FB_ADDRW-1:0] fb_addr;
    logic fb_lane;
    logic [SPR_DATAW-1:0] fb_pix;
    logic fb_we;
    logic fb_ready;
    modport master(output fb_addr, fb_lane, fb_pix, fb_we, input fb_ready);
    modport slave(input fb_addr, fb_lane, fb_pix, fb_we, output fb_ready);
endinterface

// File: rtl/sprite_dda.sv
// sprite_dda: one-axis Q4.4 DDA mapping destination pixel steps onto source pixel indices
module sprite_dda
    import sprite_pkg::*;
#(
    parameter int N = 16,
    localparam int SW = $clog2(N),
    localparam int DWW = SW + Q_INT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [SCALE_W-1:0] scale,
    input  logic step,
    input  logic restart,
    input  logic stall,
    output logic [SW-1:0] src_idx,
    output logic [DWW-1:0] dst_idx,
    output logic last
);
    logic [SCALE_W-1:0] acc;
    logic [SCALE_W:0] acc_n;
    logic [DWW-1:0] dw;
    logic hit;
    assign dw = DWW'({scale, {SW{1'b0}}} >> Q_FRAC_W);
    assign last = dst_idx == dw - DWW'(1);
    assign acc_n = {1'b0, acc} + (SCALE_W + 1)'(SCALE_ONE);
    assign hit = acc_n >= {1'b0, scale};
    always_ff @(posedge clk) begin
        if (!rst_n || restart || (step && !stall && last)) begin
            acc <= '0;
            src_idx <= '0;
            dst_idx <= '0;
        end else if (step && !stall) begin
            acc <= SCALE_W'(hit ? acc_n - {1'b0, scale} : acc_n);
            src_idx <= src_idx + SW'(hit);
            dst_idx <= dst_idx + DWW'(1);
        end
    end
endmodule

// File: rtl/sprite_blit.sv
// sprite_blit: renders a scaled, optionally mirrored, screen-clipped sprite from a synchronous ROM
// into the framebuffer write port; two-stage pipeline (ROM address, then pixel write).
module sprite_blit
    import sprite_pkg::*;
#(
    parameter int CORDW = 10,
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 480,
    parameter int SPR_W = 16,
    parameter int SPR_H = 16,
    parameter int SPR_DATAW = 4,
    parameter int TRANSP_IDX = 0,
    parameter int FB_PACK = 1,
    parameter int FB_ADDRW = 19
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic signed [CORDW:0] sx,
    input  logic signed [CORDW:0] sy,
    input  logic [SCALE_W-1:0] scale,
    input  logic flip_x,
    input  logic flip_y,
    output logic [$clog2(SPR_W*SPR_H)-1:0] spr_addr,
    input  logic [SPR_DATAW-1:0] spr_data,
    output logic busy,
    output logic done,
    sprite_blit_if.master fb
);
    localparam int XW = $clog2(SPR_W);
    localparam int YW = $clog2(SPR_H);
    localparam int PW = CORDW + 2 + XW + YW;
    state_t state, state_n;
    logic signed [CORDW:0] sx_r, sy_r;
    logic [SCALE_W-1:0] scale_r;
    logic fx_r, fy_r, restart, stall, held, v1, x_last, y_last, on_screen;
    logic [XW-1:0] src_x;
    logic [YW-1:0] src_y;
    logic [XW+Q_INT_W-1:0] dst_x;
    logic [YW+Q_INT_W-1:0] dst_y;
    logic [PW-1:0] x1, y1;
    logic [SPR_DATAW-1:0] pix, pix_r;
    logic [31:0] lin;
    assign restart = state == IDLE && start;
    assign stall = fb.fb_we && !fb.fb_ready;
    assign busy = state != IDLE;
    assign done = state == DONE;
    sprite_dda #(.N(SPR_W)) u_dda_x (
        .clk, .rst_n, .scale(scale_r), .step(state == RUN), .restart, .stall,
        .src_idx(src_x), .dst_idx(dst_x), .last(x_last)
    );
    sprite_dda #(.N(SPR_H)) u_dda_y (
        .clk, .rst_n, .scale(scale_r), .step(state == RUN && x_last), .restart, .stall,
        .src_idx(src_y), .dst_idx(dst_y), .last(y_last)
    );
    assign spr_addr = {fy_r ? ~src_y : src_y, fx_r ? ~src_x : src_x};
    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = scale < SCALE_ONE ? DONE : RUN;
            RUN:     if (!stall && x_last && y_last) state_n = DRAIN;
            DRAIN:   if (!stall) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sx_r <= '0;
            sy_r <= '0;
            scale_r <= '0;
            fx_r <= 1'b0;
            fy_r <= 1'b0;
            v1 <= 1'b0;
            x1 <= '0;
            y1 <= '0;
            held <= 1'b0;
            pix_r <= '0;
        end else begin
            if (restart) begin
                sx_r <= sx;
                sy_r <= sy;
                scale_r <= scale;
                fx_r <= flip_x;
                fy_r <= flip_y;
            end
            if (!stall) begin
                v1 <= state == RUN;
                x1 <= PW'(sx_r) + PW'(dst_x);
                y1 <= PW'(sy_r) + PW'(dst_y);
            end
            held <= stall;
            if (stall) pix_r <= pix;
        end
    end
    // the ROM already reads the next address during a stall, so the stalled pixel is kept locally
    assign pix = held ? pix_r : spr_data;
    assign on_screen = !x1[PW-1] && x1 < PW'(SCREEN_W) && !y1[PW-1] && y1 < PW'(SCREEN_H);
    assign lin = fb_lin(32'(x1), 32'(y1), SCREEN_W);
    assign fb.fb_we = v1 && on_screen && pix != SPR_DATAW'(TRANSP_IDX);
    assign fb.fb_pix = v1 ? pix : '0;
    assign fb.fb_addr = FB_ADDRW'(lin / FB_PACK);
    assign fb.fb_lane = 1'(lin % FB_PACK);
endmodule

// File: tb/tb_sprite_blit.sv
// tb_sprite_blit: directed checks of scaling, clipping, mirroring, stalls, illegal scale and reset abort;
// a second instance built with FB_PACK=2 checks word/lane addressing.
module tb_sprite_blit;
    import sprite_pkg::*;
    typedef struct packed {int addr; int lane; int pix;} wr_t;
    logic clk = 0, rst_n = 0, start = 0, flip_x = 0, flip_y = 0, rdy = 1;
    logic signed [10:0] sx = 0, sy = 0;
    logic [7:0] scale = 8'h10;
    logic [7:0] spr_addr, spr_addr2;
    logic [3:0] spr_data = 0, spr_data2 = 0;
    logic busy, done, busy2, done2;
    logic [3:0] rom [256];
    wr_t wq[$], wq2[$], eq[$];
    int n_pass = 0, n_chk = 0, ndone = 0, nwe = 0, max_addr = 0;
    sprite_blit_if #(.FB_ADDRW(19), .SPR_DATAW(4)) fb();
    sprite_blit_if #(.FB_ADDRW(19), .SPR_DATAW(4)) fb2();
    assign fb.fb_ready = rdy;
    assign fb2.fb_ready = 1'b1;
    always #5 clk = ~clk;
    sprite_blit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sx(sx), .sy(sy), .scale(scale),
        .flip_x(flip_x), .flip_y(flip_y), .spr_addr(spr_addr), .spr_data(spr_data),
        .busy(busy), .done(done), .fb(fb)
    );
    sprite_blit #(.FB_PACK(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .sx(sx), .sy(sy), .scale(scale),
        .flip_x(flip_x), .flip_y(flip_y), .spr_addr(spr_addr2), .spr_data(spr_data2),
        .busy(busy2), .done(done2), .fb(fb2)
    );
    always @(posedge clk) begin
        spr_data <= rom[spr_addr];
        spr_data2 <= rom[spr_addr2];
    end
    always @(negedge clk) begin
        if (fb.fb_we) nwe++;
        if (fb.fb_we && fb.fb_ready) begin
            wq.push_back('{int'(fb.fb_addr), int'(fb.fb_lane), int'(fb.fb_pix)});
            if (int'(fb.fb_addr) > max_addr) max_addr = int'(fb.fb_addr);
        end
        if (fb2.fb_we) wq2.push_back('{int'(fb2.fb_addr), int'(fb2.fb_lane), int'(fb2.fb_pix)});
        if (done) ndone++;
    end
    task automatic check(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask
    task automatic clear_log();
        wq.delete();
        wq2.delete();
        nwe = 0;
        ndone = 0;
        max_addr = 0;
    endtask
    task automatic kick(int x, int y, int sc, bit fx, bit fy);
        @(posedge clk); #1;
        sx = 11'(x);
        sy = 11'(y);
        scale = 8'(sc);
        flip_x = fx;
        flip_y = fy;
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask
    task automatic finish_blit(string tag);
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_timeout"}, int'(n < 5000), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask
    // destination d maps to source floor(16*d/scale); DW = DH = scale for a 16x16 sprite
    task automatic build_exp(int x0, int y0, int sc, bit fx, bit fy, int pack);
        int x, y, cx, cy, p, lin;
        eq.delete();
        for (int dy = 0; dy < sc; dy++)
            for (int dx = 0; dx < sc; dx++) begin
                x = x0 + dx;
                y = y0 + dy;
                cx = fx ? 15 - 16 * dx / sc : 16 * dx / sc;
                cy = fy ? 15 - 16 * dy / sc : 16 * dy / sc;
                p = int'(rom[cy * 16 + cx]);
                lin = y * 800 + x;
                if (p != 0 && x >= 0 && x < 800 && y >= 0 && y < 480)
                    eq.push_back('{lin / pack, lin % pack, p});
            end
    endtask
    task automatic cmp_log(string tag, bit second);
        int err = 0;
        int n = second ? wq2.size() : wq.size();
        check({tag, "_count"}, n, eq.size());
        foreach (eq[i]) if (i >= n || (second ? wq2[i] : wq[i]) != eq[i]) err++;
        check({tag, "_data_errors"}, err, 0);
    endtask
    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 4'(i % 15 + 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", fb.fb_we, 0);
        check("rst_spr_addr", spr_addr, 0);
        check("rst_fb_addr", fb.fb_addr, 0);
        check("rst_fb_lane", fb.fb_lane, 0);
        check("rst_fb_pix", fb.fb_pix, 0);
        rst_n = 1;
        clear_log();
        kick(0, 0, 16, 0, 0);
        @(negedge clk);
        check("t1_we_cycle1", fb.fb_we, 0);
        @(negedge clk);
        check("t1_we_cycle2", fb.fb_we, 1);
        check("t1_first_addr", fb.fb_addr, 0);
        check("t1_busy", busy, 1);
        finish_blit("t1");
        build_exp(0, 0, 16, 0, 0, 1);
        cmp_log("t1", 0);
        check("t1_row1_addr", wq[16].addr, 800);
        check("t1_last_addr", wq[255].addr, 12015);
        check("t1_done_pulses", ndone, 1);
        build_exp(0, 0, 16, 0, 0, 2);
        cmp_log("t1_pack2", 1);
        check("t1_pack2_x1_addr", wq2[1].addr, 0);
        check("t1_pack2_x1_lane", wq2[1].lane, 1);
        check("t1_pack2_row1_addr", wq2[17].addr, 400);
        check("t1_pack2_row1_lane", wq2[17].lane, 1);
        clear_log();
        kick(0, 0, 32, 0, 0);
        finish_blit("t2a");
        build_exp(0, 0, 32, 0, 0, 1);
        cmp_log("t2a", 0);
        check("t2a_pix_x1", wq[1].pix, 1);
        check("t2a_pix_x2", wq[2].pix, 2);
        check("t2a_row1_addr", wq[32].addr, 800);
        check("t2a_row1_pix", wq[32].pix, 1);
        clear_log();
        kick(0, 0, 24, 0, 0);
        finish_blit("t2b");
        build_exp(0, 0, 24, 0, 0, 1);
        cmp_log("t2b", 0);
        check("t2b_pix_x1", wq[1].pix, 1);
        check("t2b_pix_x2", wq[2].pix, 2);
        check("t2b_pix_x3", wq[3].pix, 3);
        check("t2b_pix_x4", wq[4].pix, 3);
        clear_log();
        kick(-4, 470, 16, 0, 0);
        finish_blit("t3");
        build_exp(-4, 470, 16, 0, 0, 1);
        cmp_log("t3", 0);
        check("t3_writes", wq.size(), 120);
        check("t3_first_addr", wq[0].addr, 376000);
        check("t3_first_pix", wq[0].pix, 5);
        check("t3_addr_in_screen", int'(max_addr < 384000), 1);
        check("t3_done_pulses", ndone, 1);
        for (int i = 0; i < 256; i++) rom[i] = (i % 16 == 0) ? 4'd5 : 4'd0;
        clear_log();
        kick(0, 0, 16, 1, 0);
        finish_blit("t4");
        build_exp(0, 0, 16, 1, 0, 1);
        cmp_log("t4", 0);
        check("t4_we_cycles", nwe, 16);
        check("t4_first_addr", wq[0].addr, 15);
        check("t4_first_pix", wq[0].pix, 5);
        for (int i = 0; i < 256; i++) rom[i] = 4'(i % 15 + 1);
        clear_log();
        kick(0, 0, 16, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        rdy = 0;
        start = 1;
        @(negedge clk);
        check("t5_stall_we", fb.fb_we, 1);
        check("t5_stall_addr", fb.fb_addr, 4);
        check("t5_stall_pix", fb.fb_pix, 5);
        @(posedge clk); #1;
        start = 0;
        repeat (2) begin
            @(negedge clk);
            check("t5_hold_addr", fb.fb_addr, 4);
            check("t5_hold_pix", fb.fb_pix, 5);
            check("t5_hold_we", fb.fb_we, 1);
            @(posedge clk); #1;
        end
        rdy = 1;
        finish_blit("t5");
        build_exp(0, 0, 16, 0, 0, 1);
        cmp_log("t5", 0);
        check("t5_done_pulses", ndone, 1);
        check("t5_no_restart", busy, 0);
        clear_log();
        kick(0, 0, 8, 0, 0);
        @(negedge clk);
        check("t6a_busy", busy, 1);
        check("t6a_done", done, 1);
        @(negedge clk);
        check("t6a_busy_after", busy, 0);
        check("t6a_done_after", done, 0);
        repeat (4) @(posedge clk);
        #1;
        check("t6a_writes", nwe, 0);
        check("t6a_done_pulses", ndone, 1);
        clear_log();
        kick(0, 0, 16, 0, 0);
        repeat (50) @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("t6b_busy", busy, 0);
        check("t6b_we", fb.fb_we, 0);
        repeat (5) @(posedge clk);
        #1;
        check("t6b_writes", wq.size(), 50);
        check("t6b_no_done", ndone, 0);
        check("t6b_idle", busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
